mccoy_sequencer: RTL and testbench
==================================

Name: mccoy_sequencer

Overview:
Program sequencer for the McCoy 6-bit accumulator core. It buffers a short instruction program (li/sr/add/not encodings) loaded over a valid/ready port. On start it pulses the core reset, then issues one instruction per clock on the core's 6-bit instr input, then parks the core on a NOP. It sits between the tile pins/host logic and io_in[7:2] of the core, replacing hand-driven instruction streams.

Parameters:
DEPTH, 16, program buffer entries (power of two, 2..64)
AW, 4, address width, log2(DEPTH)
NOP_INSTR, 6'b000000, word driven on instr_out whenever no program instruction is issued

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
load_valid  input  1  program word offered
load_data  input  6  program word
load_ready  output  1  buffer accepts word this cycle
clear  input  1  discard program (length := 0)
start  input  1  begin run (level sampled per cycle)
stop  input  1  abort run
instr_out  output  6  instruction to core io_in[7:2]
core_rst  output  1  active-high reset to core io_in[1]
busy  output  1  run in progress
done  output  1  program completed, held until next start/clear
pc  output  AW+1  index of next word to issue

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on reset_n. All state is cleared immediately on reset_n low.
- Reset values: state=IDLE, wr_ptr=0, len=0, pc=0, instr_out=NOP_INSTR, core_rst=0, load_ready=0 (1 from first cycle after reset release), busy=0, done=0. Buffer contents are not reset.
- States: IDLE, CRST, RUN, DONE.
- IDLE:
  - load_ready = (len < DEPTH).
  - A transfer (load_valid & load_ready) writes mem[len], and len increments.
  - At len==DEPTH, load_ready=0 and further words are ignored.
  - clear sets len=0.
  - start with len>0 (after any same-cycle load) goes to CRST. start with len==0 is ignored.
  - clear beats start in the same cycle.
- CRST (1 cycle): core_rst=1, instr_out=NOP_INSTR, busy=1, pc=0, load_ready=0.
- RUN:
  - Each cycle, register instr_out=mem[pc] and increment pc.
  - After issuing word len-1, go to DONE.
  - Latency: start sampled at edge N → core_rst high between edges N+1 and N+2 → first word valid after edge N+2 → last word after edge N+1+len → done=1 after edge N+2+len.
  - stop in RUN: next edge goes to IDLE with instr_out=NOP_INSTR, busy=0, done=0. The program is retained.
- DONE:
  - done=1, busy=0, instr_out=NOP_INSTR, load_ready = (len < DEPTH).
  - Loads append as in IDLE.
  - start re-runs (to CRST).
  - clear goes to IDLE with len=0.
- load_valid, clear and start are ignored in CRST/RUN. Only stop and reset act there.
- reset_n low mid-run immediately forces the reset values. core_rst is not asserted by the sequencer's own reset.
- instr_out and core_rst are registered outputs (glitch-free for pins).

Optional Feature:
STEP_EN
- Defined: adds input step (1 bit).
  - In RUN, a word is issued and pc increments only in cycles with step=1. Otherwise instr_out=NOP_INSTR and pc holds.
  - Core clock gating is the integrator's concern.
  - CRST is still a single cycle regardless of step.
  - done follows the edge after the step that issued the last word.
- Undefined: no step port; RUN issues one word every cycle as above.

Test Plan:
- Load 011000, 010100, 010000, 010001 (li 3, sr x2, li 2, add x2), then pulse start at edge N → core_rst=1 only after N+1; instr_out = 011000, 010100, 010000, 010001 after edges N+2..N+5; NOP afterwards; done=1 after N+6. With core attached, core output = 5.
- Load 17 words with DEPTH=16 → load_ready drops after the 16th accept; 17th word not stored; run issues exactly 16 words.
- start with empty buffer → stays IDLE, core_rst never asserts, busy=0. Same-cycle load+start on empty buffer → one-word run.
- stop after 2 words of a 6-word program → instr_out=NOP next cycle, busy=0, done=0. Restart → core_rst pulse and full 6-word sequence from pc=0.
- reset_n low mid-RUN (asynchronous, between edges) → instr_out=NOP_INSTR, busy=0, len=0 immediately. clear+start same cycle in DONE → IDLE, len=0, no run.
- STEP_EN: 3-word program with step high only on alternate cycles → words issued only in step cycles with NOPs between; done after the third step.

Source files
------------

// File: rtl/mccoy_sequencer_if.sv
// Program-load channel of the McCoy sequencer: valid/ready handshake carrying one 6-bit instruction word.
// The host side uses the master modport; the sequencer uses the slave modport.
interface mccoy_sequencer_if;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/mccoy_sequencer.sv
// Program sequencer for the McCoy 6-bit accumulator core: buffers a program, pulses core reset, then streams it.
// Optional macro STEP_EN adds a 'step' input that gates word issue in RUN.
//
// state | meaning
// IDLE  | program loadable, waiting for start
// CRST  | one cycle; core_rst asserts on the following cycle
// RUN   | issuing mem[pc] each (step) cycle until pc reaches len
// DONE  | program finished, loads append, start re-runs
module mccoy_sequencer #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [5:0] NOP_INSTR = 6'b000000
) (
    input  logic                clk,
    input  logic                reset_n,
    mccoy_sequencer_if.slave    ld,
    input  logic                clear,
    input  logic                start,
    input  logic                stop,
`ifdef STEP_EN
    input  logic                step,
`endif
    output logic [5:0]          instr_out,
    output logic                core_rst,
    output logic                busy,
    output logic                done,
    output logic [AW:0]         pc
);

    typedef enum logic [1:0] {IDLE, CRST, RUN, DONE} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [5:0]  mem [DEPTH];
    logic [AW:0] len, len_nxt, pc_nxt;
    logic [5:0]  instr_nxt;
    logic        rdy_en, load_ok, xfer, issue_ok;

`ifdef STEP_EN
    assign issue_ok = step;
`else
    assign issue_ok = 1'b1;
`endif

    // rdy_en keeps load_ready low until the first edge after reset release
    assign load_ok       = rdy_en && ((state == IDLE) || (state == DONE)) && (len < FULL);
    assign ld.load_ready = load_ok;
    assign xfer          = ld.load_valid && load_ok;
    assign busy          = (state == CRST) || (state == RUN);
    assign done          = (state == DONE);

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        pc_nxt    = pc;
        instr_nxt = NOP_INSTR;
        case (state)
            IDLE, DONE: begin
                if (xfer)
                    len_nxt = len + ONE;
                if (clear) begin
                    len_nxt   = '0;
                    state_nxt = IDLE;
                end else if (start && (len_nxt != '0)) begin
                    state_nxt = CRST;
                    pc_nxt    = '0;
                end
            end
            CRST: state_nxt = stop ? IDLE : RUN;
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (pc == len) begin
                    state_nxt = DONE;
                end else if (issue_ok) begin
                    instr_nxt = mem[pc[AW-1:0]];
                    pc_nxt    = pc + ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len       <= '0;
            pc        <= '0;
            instr_out <= NOP_INSTR;
            core_rst  <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            pc        <= pc_nxt;
            instr_out <= instr_nxt;
            // registered one cycle behind CRST so the pin sees a clean single-cycle pulse
            core_rst  <= (state == CRST) && !stop;
            rdy_en    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer)
            mem[len[AW-1:0]] <= ld.load_data;
    end

endmodule

// File: tb/tb_mccoy_sequencer.sv
// Self-checking bench for mccoy_sequencer: program model plus expected-word queue popped as the DUT issues.
module tb_mccoy_sequencer;
    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [5:0] NOP   = 6'b000000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0, start = 1'b0, stop = 1'b0;
`ifdef STEP_EN
    logic          step = 1'b1;
`endif
    logic [5:0]    instr_out;
    logic          core_rst, busy, done;
    logic [AW:0]   pc;

    int            checks = 0;
    int            failures = 0;
    logic [5:0]    model_mem[$];
    logic [5:0]    exp_q[$];

    mccoy_sequencer_if ld();

    mccoy_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld        (ld.slave),
        .clear     (clear),
        .start     (start),
        .stop      (stop),
`ifdef STEP_EN
        .step      (step),
`endif
        .instr_out (instr_out),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [5:0] w);
        logic exp_rdy;
        exp_rdy = (model_mem.size() < DEPTH);
        ld.load_valid = 1'b1;
        ld.load_data  = w;
        checks++;
        if (ld.load_ready !== exp_rdy) begin
            failures++;
            $display("FAIL load_ready got=%b exp=%b words=%0d", ld.load_ready, exp_rdy, model_mem.size());
        end
        tick();
        if (exp_rdy) model_mem.push_back(w);
        ld.load_valid = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_mem.delete();
    endtask

    // start (and any load) is already driven; the next edge is the start-sample edge N
    task automatic do_run(input int stop_after);
        int n;
        logic [5:0] exp;
        n = model_mem.size();
        foreach (model_mem[k]) exp_q.push_back(model_mem[k]);
        tick();
        start = 1'b0;
        ld.load_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || core_rst !== 1'b0) begin
            failures++;
            $display("FAIL crst_entry got busy=%b core_rst=%b exp busy=1 core_rst=0", busy, core_rst);
        end
        tick();
        checks++;
        if (core_rst !== 1'b1 || instr_out !== NOP || pc !== '0) begin
            failures++;
            $display("FAIL core_rst_pulse got rst=%b instr=%b pc=%0d exp rst=1 instr=%b pc=0", core_rst, instr_out, pc, NOP);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (instr_out !== exp || core_rst !== 1'b0) begin
                failures++;
                $display("FAIL run_word[%0d] got instr=%b rst=%b exp instr=%b rst=0", i, instr_out, core_rst, exp);
            end
            if (i + 1 == stop_after) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                checks++;
                if (instr_out !== NOP || busy !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL stop got instr=%b busy=%b done=%b exp instr=%b busy=0 done=0", instr_out, busy, done, NOP);
                end
                exp_q.delete();
                return;
            end
        end
        tick();
        checks++;
        if (instr_out !== NOP || done !== 1'b1 || busy !== 1'b0 || pc !== (AW+1)'(n)) begin
            failures++;
            $display("FAIL run_done got instr=%b done=%b busy=%b pc=%0d exp instr=%b done=1 busy=0 pc=%0d", instr_out, done, busy, pc, NOP, n);
        end
    endtask

    task automatic test_reset;
        ld.load_valid = 1'b0;
        ld.load_data  = '0;
        reset_n = 1'b0;
        #12;
        checks++;
        if (instr_out !== NOP || core_rst !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== '0 || ld.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got instr=%b rst=%b busy=%b done=%b pc=%0d rdy=%b exp all zero", instr_out, core_rst, busy, done, pc, ld.load_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (ld.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b exp=0", ld.load_ready);
        end
        tick();
        checks++;
        if (ld.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%b exp=1", ld.load_ready);
        end
    endtask

    task automatic test_basic;
        load_word(6'b011000);
        load_word(6'b010100);
        load_word(6'b010000);
        load_word(6'b010001);
        start = 1'b1;
        do_run(0);
    endtask

    task automatic test_overflow;
        do_clear();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_from_done got done=%b busy=%b exp 0 0", done, busy);
        end
        for (int i = 0; i < DEPTH + 1; i++) load_word(6'($urandom_range(0, 63)));
        checks++;
        if (ld.load_ready !== 1'b0 || model_mem.size() != DEPTH) begin
            failures++;
            $display("FAIL full_ready got=%b words=%0d exp rdy=0 words=%0d", ld.load_ready, model_mem.size(), DEPTH);
        end
        start = 1'b1;
        do_run(0);
    endtask

    task automatic test_empty_start;
        logic [5:0] w;
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_start_busy got=%b exp=0", busy);
        end
        tick();
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b0 || instr_out !== NOP) begin
            failures++;
            $display("FAIL empty_start_idle got rst=%b busy=%b instr=%b exp 0 0 %b", core_rst, busy, instr_out, NOP);
        end
        w = 6'b011100;
        ld.load_valid = 1'b1;
        ld.load_data  = w;
        start = 1'b1;
        checks++;
        if (ld.load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_start_ready got=%b exp=1", ld.load_ready);
        end
        model_mem.push_back(w);
        do_run(0);
    endtask

    task automatic test_stop;
        do_clear();
        for (int i = 0; i < 6; i++) load_word(6'(8 + 3 * i));
        start = 1'b1;
        do_run(2);
        start = 1'b1;
        do_run(0);
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (instr_out !== NOP || busy !== 1'b0 || pc !== '0 || core_rst !== 1'b0 || ld.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got instr=%b busy=%b pc=%0d rst=%b rdy=%b exp %b 0 0 0 0", instr_out, busy, pc, core_rst, ld.load_ready, NOP);
        end
        model_mem.delete();
        #2;
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_len_zero got busy=%b exp=0", busy);
        end
        tick();
        checks++;
        if (core_rst !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_crst got=%b exp=0", core_rst);
        end
    endtask

    task automatic test_clear_start_done;
        load_word(6'b010111);
        load_word(6'b100000);
        start = 1'b1;
        do_run(0);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        model_mem.delete();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_beats_start got done=%b busy=%b exp 0 0", done, busy);
        end
        tick();
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_start_norun got rst=%b busy=%b exp 0 0", core_rst, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cleared_len_start got busy=%b exp=0", busy);
        end
    endtask

`ifdef STEP_EN
    task automatic test_step;
        logic [5:0] exp;
        do_clear();
        load_word(6'b011010);
        load_word(6'b110000);
        load_word(6'b010011);
        foreach (model_mem[k]) exp_q.push_back(model_mem[k]);
        start = 1'b1;
        step = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL step_crst got=%b exp=1", core_rst);
        end
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (instr_out !== exp || pc !== (AW+1)'(i + 1)) begin
                failures++;
                $display("FAIL step_word[%0d] got instr=%b pc=%0d exp instr=%b pc=%0d", i, instr_out, pc, exp, i + 1);
            end
            step = 1'b0;
            tick();
            checks++;
            if (instr_out !== NOP || pc !== (AW+1)'(i + 1) || done !== (i == 2)) begin
                failures++;
                $display("FAIL step_gap[%0d] got instr=%b pc=%0d done=%b exp instr=%b pc=%0d done=%b", i, instr_out, pc, done, NOP, i + 1, i == 2);
            end
        end
        step = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty_start();
        test_stop();
        test_reset_mid();
        test_clear_start_done();
`ifdef STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
